// File: rtl/spinv_pkg.sv
// rtl/spinv_pkg.sv - shared types, row indices and screen limits for the invader fleet
package spinv_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARCH,
    ST_DESCEND,
    ST_CLEARED,
    ST_OVERRUN
  } state_t;

  localparam logic [1:0] ROW_TOP = 2'd0;
  localparam logic [1:0] ROW_MID = 2'd1;
  localparam logic [1:0] ROW_BOT = 2'd2;

  localparam int SCR_X_MIN  = 10;
  localparam int SCR_X_MAX  = 130;
  localparam int SCR_Y_LOSE = 400;

  // Coordinates pin at 1023 rather than wrapping back to the top of the screen.
  function automatic coord_t sat_add(input coord_t a, input int b);
    logic [10:0] s;
    s = {1'b0, a} + 11'(b);
    return s[10] ? '1 : s[9:0];
  endfunction

endpackage

// File: rtl/spinv_fleet_ctrl_if.sv
// rtl/spinv_fleet_ctrl_if.sv - hit request/acknowledge channel between projectile tracker and fleet
interface spinv_fleet_ctrl_if;
  logic       hit_valid;
  logic [1:0] hit_row;
  logic [2:0] hit_col;
  logic       hit_ack;
  logic       hit_kill;

  modport master (output hit_valid, hit_row, hit_col, input hit_ack, hit_kill);
  modport slave  (input hit_valid, hit_row, hit_col, output hit_ack, hit_kill);
endinterface

// File: rtl/spinv_step_timer.sv
// rtl/spinv_step_timer.sv - step interval counter, period re-sampled on clear and at each wrap
module spinv_step_timer #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] period_q;

  // A zero period behaves as one so the fleet can never stall.
  assign tc = en && !clear && ((cnt_q + W'(1)) >= period_q);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else if (clear) begin
      cnt_q    <= '0;
      period_q <= period;
    end else if (en) begin
      if (tc) begin
        cnt_q    <= '0;
        period_q <= period;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/spinv_fleet_ctrl.sv
// rtl/spinv_fleet_ctrl.sv - invader formation sequencer: march, descend, hit resolution, win/lose
// Optional SPINV_SPEEDUP_EN: step period shrinks with the number of aliens left alive.
module spinv_fleet_ctrl
  import spinv_pkg::*;
#(
  parameter int COLS        = 5,
  parameter int INIT_X      = 30,
  parameter int INIT_TOP_Y  = 30,
  parameter int ROW_PITCH   = 60,
  parameter int STEP_X      = 10,
  parameter int STEP_Y      = 20,
  parameter int X_MIN       = SCR_X_MIN,
  parameter int X_MAX       = SCR_X_MAX,
  parameter int Y_LOSE      = SCR_Y_LOSE,
  parameter int BASE_PERIOD = 2_000_000
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  spinv_fleet_ctrl_if.slave hit,
  output coord_t            xInvader,
  output coord_t            topY,
  output coord_t            midY,
  output coord_t            botY,
  output logic [COLS-1:0]   topRow,
  output logic [COLS-1:0]   midRow,
  output logic [COLS-1:0]   botRow,
  output logic              step_pulse,
  output logic              win,
  output logic              lose
);

  localparam int N  = 3 * COLS;
  localparam int CW = $clog2(N + 1);

  state_t          state_q, state_n;
  coord_t          x_n, top_n, mid_n, bot_n;
  logic [N-1:0]    alive_q, alive_n, hit_bit;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            dir_q, dir_n;  // 1 = moving right
  logic            kill_n, active, start_go, step_tc;
  logic [31:0]     period;

  assign active   = (state_q == ST_MARCH) || (state_q == ST_DESCEND);
  assign start_go = start && !active;

  assign hit_bit = ((hit.hit_row <= ROW_BOT) && ({29'd0, hit.hit_col} < 32'(COLS)))
                 ? (N'(1) << (int'(hit.hit_row) * COLS + int'(hit.hit_col))) : '0;

`ifdef SPINV_SPEEDUP_EN
  assign period = start_go ? 32'((BASE_PERIOD / 16) * (N + 1))
                           : 32'(BASE_PERIOD / 16) * (32'(cnt_q) + 32'd1);
`else
  assign period = 32'(BASE_PERIOD);
`endif

  spinv_step_timer #(.W(32)) u_timer (
    .Clk    (Clk),
    .reset  (reset),
    .clear  (start_go),
    .en     (active),
    .period (period),
    .tc     (step_tc)
  );

  always_comb begin
    state_n = state_q;
    x_n     = xInvader;
    top_n   = topY;
    mid_n   = midY;
    bot_n   = botY;
    alive_n = alive_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    kill_n  = 1'b0;
    if (start_go) begin
      state_n = ST_MARCH;
      x_n     = coord_t'(INIT_X);
      top_n   = coord_t'(INIT_TOP_Y);
      mid_n   = coord_t'(INIT_TOP_Y + ROW_PITCH);
      bot_n   = coord_t'(INIT_TOP_Y + 2 * ROW_PITCH);
      alive_n = '1;
      cnt_n   = CW'(N);
      dir_n   = 1'b1;
    end else if (active) begin
      if (step_tc) begin
        if (state_q == ST_MARCH) begin
          if (dir_q) begin
            if (({1'b0, xInvader} + 11'(STEP_X)) > 11'(X_MAX)) state_n = ST_DESCEND;
            else x_n = xInvader + coord_t'(STEP_X);
          end else begin
            if ({1'b0, xInvader} < 11'(X_MIN + STEP_X)) state_n = ST_DESCEND;
            else x_n = xInvader - coord_t'(STEP_X);
          end
        end else begin
          top_n   = sat_add(topY, STEP_Y);
          mid_n   = sat_add(midY, STEP_Y);
          bot_n   = sat_add(botY, STEP_Y);
          dir_n   = !dir_q;
          state_n = (bot_n >= coord_t'(Y_LOSE)) ? ST_OVERRUN : ST_MARCH;
        end
      end
      // Applied after the step so a final kill overrides an overrun on the same edge.
      if (hit.hit_valid && |(alive_q & hit_bit)) begin
        alive_n = alive_q & ~hit_bit;
        cnt_n   = cnt_q - CW'(1);
        kill_n  = 1'b1;
        if (cnt_q == CW'(1)) state_n = ST_CLEARED;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      xInvader     <= coord_t'(INIT_X);
      topY         <= coord_t'(INIT_TOP_Y);
      midY         <= coord_t'(INIT_TOP_Y + ROW_PITCH);
      botY         <= coord_t'(INIT_TOP_Y + 2 * ROW_PITCH);
      alive_q      <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b1;
      hit.hit_ack  <= 1'b0;
      hit.hit_kill <= 1'b0;
      step_pulse   <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state_q      <= state_n;
      xInvader     <= x_n;
      topY         <= top_n;
      midY         <= mid_n;
      botY         <= bot_n;
      alive_q      <= alive_n;
      cnt_q        <= cnt_n;
      dir_q        <= dir_n;
      hit.hit_ack  <= hit.hit_valid;
      hit.hit_kill <= kill_n;
      step_pulse   <= step_tc;
      win          <= (state_n == ST_CLEARED);
      lose         <= (state_n == ST_OVERRUN);
    end
  end

  assign topRow = alive_q[COLS-1:0];
  assign midRow = alive_q[2*COLS-1:COLS];
  assign botRow = alive_q[N-1:2*COLS];

endmodule
